// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared definitions for the RV32I pipeline slice: opcode constants used by
// the legality screen, ResultSrc encodings, default datapath width, the
// packed control bundle carried from Decode into Execute, and the encoding
// of the ID/EX next-state decision.
package riscv_pkg;

  localparam int XLEN_DEF = 32;

  // Opcodes the MainDecoder understands. Anything else gets screened out
  // before it reaches Execute.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ResultSrc encodings.
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Control fields registered from Decode into Execute.
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [1:0] result_src;
    logic [2:0] alu_control;
  } ctrl_t;

  // What the ID/EX register does at the next clock edge (reset is handled
  // separately, ahead of this decision).
  typedef enum logic [2:0] {
    ACT_IDLE     = 3'd0,  // no valid D instruction: plain bubble
    ACT_CAPTURE  = 3'd1,  // legal D instruction moves into E
    ACT_FLUSH    = 3'd2,  // taken branch/jump squashes the wrong-path D
    ACT_LOAD_USE = 3'd3,  // load-use hazard: bubble while D is held
    ACT_ILLEGAL  = 3'd4   // illegal opcode: bubble flagged as illegal
  } ex_action_t;

  // Only exact matches count as legal, so an opcode carrying X or Z bits
  // falls into the default arm and is treated as illegal.
  function automatic logic is_legal_op(input logic [6:0] op);
    logic legal;
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_ITYPE, OP_JAL: legal = 1'b1;
      default:                                                   legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Actions that insert a bubble worth counting.
  function automatic logic is_counted_bubble(input ex_action_t act);
    return (act == ACT_FLUSH) || (act == ACT_LOAD_USE) || (act == ACT_ILLEGAL);
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect
// Combinational hazard logic at the Decode/Execute boundary.
//   valid_e_i       E slot holds a real instruction
//   result_src_e_i  ResultSrc of the instruction in E
//   rd_e_i          destination register of the instruction in E
//   valid_d_i       D slot holds a real instruction
//   rs1_d_i/rs2_d_i source registers of the instruction in D
//   pcsrc_e_i       taken branch/jump resolved in E this cycle
//   lw_stall_o      load in E produces a register the D instruction reads
//   stall_f_o       hold the PC
//   stall_d_o       hold the IF/ID register
//   flush_d_o       clear the IF/ID register
module hazard_detect
  import riscv_pkg::*;
(
  input  logic       valid_e_i,
  input  logic [1:0] result_src_e_i,
  input  logic [4:0] rd_e_i,
  input  logic       valid_d_i,
  input  logic [4:0] rs1_d_i,
  input  logic [4:0] rs2_d_i,
  input  logic       pcsrc_e_i,
  output logic       lw_stall_o,
  output logic       stall_f_o,
  output logic       stall_d_o,
  output logic       flush_d_o
);

  logic load_in_e;
  logic rd_matches;

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  assign load_in_e  = valid_e_i && (result_src_e_i == RES_MEM) && (rd_e_i != 5'd0);
  assign rd_matches = (rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i);
  assign lw_stall_o = load_in_e && rd_matches && valid_d_i;

  // A taken branch/jump makes the D instruction wrong-path; holding it would
  // only preserve something that is about to be discarded, so flush wins.
  assign stall_f_o  = lw_stall_o && !pcsrc_e_i;
  assign stall_d_o  = lw_stall_o && !pcsrc_e_i;
  assign flush_d_o  = pcsrc_e_i;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
// Decode->Execute pipeline register of the 5-stage RV32I core.
// Captures decoded controls and datapath fields into E, resolves PCSrcE from
// the ALU zero flag, detects load-use hazards, screens illegal opcodes and
// counts the bubbles it inserts (saturating).
//
// Valid semantics: ValidD marks a real instruction in D; it is captured one
// cycle later as ValidE unless a flush, load-use stall or illegal opcode
// turns that slot into a bubble. There is no back-pressure other than
// StallF/StallD, which ask the upstream stages to hold the D instruction so
// it is presented again on the next cycle.
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   ValidD, OpD              D instruction present, opcode for legality screen
//   *D controls/data/indices decoded fields of the D instruction
//   ZeroE                    ALU zero flag of the instruction in E
//   *E outputs               registered copies of the D fields
//   ValidE, IllegalE         E holds a real instruction / E bubble came from an illegal op
//   PCSrcE                   take branch/jump target
//   StallF, StallD, FlushD   hazard controls for the front end
//   BubbleCnt                saturating count of inserted bubbles
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ValidD,
  input  logic [6:0]       OpD,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             JumpD,
  input  logic             BranchD,
  input  logic             ALUSrcD,
  input  logic [1:0]       ResultSrcD,
  input  logic [2:0]       ALUControlD,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [XLEN-1:0]  PCD,
  input  logic [XLEN-1:0]  ImmExtD,
  input  logic [XLEN-1:0]  PCPlus4D,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic             ZeroE,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             JumpE,
  output logic             BranchE,
  output logic             ALUSrcE,
  output logic [1:0]       ResultSrcE,
  output logic [2:0]       ALUControlE,
  output logic [XLEN-1:0]  RD1E,
  output logic [XLEN-1:0]  RD2E,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic             ValidE,
  output logic             IllegalE,
  output logic             PCSrcE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic [CNT_W-1:0] BubbleCnt
);

  // ---------------------------------------------------------------------------
  // E-stage state
  // ---------------------------------------------------------------------------
  ctrl_t             ctrl_q,    ctrl_d;
  logic [XLEN-1:0]   rd1_q,     rd1_d;
  logic [XLEN-1:0]   rd2_q,     rd2_d;
  logic [XLEN-1:0]   pc_q,      pc_d;
  logic [XLEN-1:0]   imm_q,     imm_d;
  logic [XLEN-1:0]   pcp4_q,    pcp4_d;
  logic [4:0]        rs1_q,     rs1_d;
  logic [4:0]        rs2_q,     rs2_d;
  logic [4:0]        rd_q,      rd_d;
  logic              valid_q,   valid_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;

  logic              pcsrc_e;
  logic              lw_stall;
  ex_action_t        act;

  // ---------------------------------------------------------------------------
  // Branch resolution and hazards
  // ---------------------------------------------------------------------------
  // Gated by valid_q so a bubble can never redirect the PC, even though a
  // bubble's controls are already zero.
  assign pcsrc_e = ((ctrl_q.branch && ZeroE) || ctrl_q.jump) && valid_q;

  hazard_detect u_hazard_detect (
    .valid_e_i      (valid_q),
    .result_src_e_i (ctrl_q.result_src),
    .rd_e_i         (rd_q),
    .valid_d_i      (ValidD),
    .rs1_d_i        (Rs1D),
    .rs2_d_i        (Rs2D),
    .pcsrc_e_i      (pcsrc_e),
    .lw_stall_o     (lw_stall),
    .stall_f_o      (StallF),
    .stall_d_o      (StallD),
    .flush_d_o      (FlushD)
  );

  // ---------------------------------------------------------------------------
  // Next-state decision, in priority order
  // ---------------------------------------------------------------------------
  always_comb begin
    act = ACT_IDLE;
    if (pcsrc_e) begin
      act = ACT_FLUSH;
    end else if (lw_stall) begin
      act = ACT_LOAD_USE;
    end else if (ValidD && !is_legal_op(OpD)) begin
      act = ACT_ILLEGAL;
    end else if (ValidD) begin
      act = ACT_CAPTURE;
    end
  end

  // Every non-capture action produces an all-zero bubble, so whatever the
  // decoder drives for an illegal or absent instruction (including Z) never
  // reaches the E outputs.
  always_comb begin
    ctrl_d    = '0;
    rd1_d     = '0;
    rd2_d     = '0;
    pc_d      = '0;
    imm_d     = '0;
    pcp4_d    = '0;
    rs1_d     = '0;
    rs2_d     = '0;
    rd_d      = '0;
    valid_d   = 1'b0;
    illegal_d = 1'b0;
    cnt_d     = cnt_q;

    case (act)
      ACT_CAPTURE: begin
        ctrl_d.reg_write   = RegWriteD;
        ctrl_d.mem_write   = MemWriteD;
        ctrl_d.jump        = JumpD;
        ctrl_d.branch      = BranchD;
        ctrl_d.alu_src     = ALUSrcD;
        ctrl_d.result_src  = ResultSrcD;
        ctrl_d.alu_control = ALUControlD;
        rd1_d              = RD1D;
        rd2_d              = RD2D;
        pc_d               = PCD;
        imm_d              = ImmExtD;
        pcp4_d             = PCPlus4D;
        rs1_d              = Rs1D;
        rs2_d              = Rs2D;
        rd_d               = RdD;
        valid_d            = 1'b1;
      end
      ACT_ILLEGAL: begin
        illegal_d = 1'b1;
      end
      default: begin
      end
    endcase

    // Plain idle slots are not counted; only bubbles this stage forces.
    if (is_counted_bubble(act) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // ID/EX register bank and bubble counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      pc_q      <= '0;
      imm_q     <= '0;
      pcp4_q    <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
      pc_q      <= pc_d;
      imm_q     <= imm_d;
      pcp4_q    <= pcp4_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign RegWriteE   = ctrl_q.reg_write;
  assign MemWriteE   = ctrl_q.mem_write;
  assign JumpE       = ctrl_q.jump;
  assign BranchE     = ctrl_q.branch;
  assign ALUSrcE     = ctrl_q.alu_src;
  assign ResultSrcE  = ctrl_q.result_src;
  assign ALUControlE = ctrl_q.alu_control;
  assign RD1E        = rd1_q;
  assign RD2E        = rd2_q;
  assign PCE         = pc_q;
  assign ImmExtE     = imm_q;
  assign PCPlus4E    = pcp4_q;
  assign Rs1E        = rs1_q;
  assign Rs2E        = rs2_q;
  assign RdE         = rd_q;
  assign ValidE      = valid_q;
  assign IllegalE    = illegal_q;
  assign PCSrcE      = pcsrc_e;
  assign BubbleCnt   = cnt_q;

endmodule
